imem_loader: RTL and testbench

- Boot-time programming controller for the instruction memory: receives a framed byte stream (e.g. from the UART receiver), assembles little-endian words and drives a write port on the instruction memory.
- While a load is in progress, holds the core off instruction fetch via core_hold.
- Sits between the UART RX byte interface, the instruction memory write port and the core's stall/reset logic.

---
 rtl/imem_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_imem_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader -- boot-time instruction memory programmer.
//
// Receives a framed byte stream, assembles little-endian 32-bit words and
// writes them to the instruction memory, holding the core off fetch while a
// load is in progress.
//
// Frame: 0xA5, CNT_LO, CNT_HI, 4*CNT data bytes, CSUM (mod-256 sum of data).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   byte stream valid
//   in_data    in   byte stream data [7:0]
//   in_ready   out  byte accepted when in_valid && in_ready (1 after reset)
//   imem_we    out  one-cycle word write strobe
//   imem_waddr out  word write address [AWIDTH-1:0]
//   imem_wdata out  word write data [DWIDTH-1:0]
//   core_hold  out  keeps the core stalled while high
//   load_done  out  one-cycle pulse on a successful load
//   load_err   out  sticky error flag, cleared at the next frame start
//
// Optional feature: define LOADER_TIMEOUT_EN to abort a frame after
// TIMEOUT_CYCLES consecutive cycles without a byte while mid-frame.
module imem_loader #(
  parameter int DWIDTH         = 32,
  parameter int AWIDTH         = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [AWIDTH-1:0] imem_waddr,
  output logic [DWIDTH-1:0] imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  localparam logic [16:0] MAX_CNT = 17'(1 << AWIDTH);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_in_ready;
  logic                r_we;
  logic [AWIDTH-1:0]   r_waddr;
  logic [DWIDTH-1:0]   r_wdata;
  logic                r_hold;
  logic                r_done;
  logic                r_err;
  logic [7:0]          r_cnt_lo;
  logic [15:0]         r_words_left;
  logic [AWIDTH-1:0]   r_addr;
  logic [1:0]          r_byte_idx;
  logic [DWIDTH-9:0]   r_asm;        // first three bytes of the current word
  logic [7:0]          r_sum;

  logic                w_accept;
  logic [15:0]         w_cnt;
  logic                w_cnt_big;
  logic                w_last_word;
  logic                w_start;
  logic                w_len_err;
  logic                w_word_done;
  logic                w_csum_ok;
  logic                w_csum_bad;
  logic                w_tmo;

  assign w_accept    = in_valid & r_in_ready;
  assign w_cnt       = {in_data, r_cnt_lo};
  assign w_cnt_big   = ({1'b0, w_cnt} > MAX_CNT);
  assign w_last_word = (r_words_left == 16'd1);

`ifdef LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] r_tmo;

  // Idle-byte counter: runs only mid-frame, cleared by every accepted byte.
  always_ff @(posedge clk) begin
    if (!rst_n || (r_state == S_IDLE) || w_accept) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a timeout overrides whatever the frame parser wants.
  always_comb begin
    w_state_next = r_state;
    if (w_tmo) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_next = w_start ? S_LEN0 : S_IDLE;
        S_LEN0: w_state_next = w_accept ? S_LEN1 : S_LEN0;
        S_LEN1: begin
          if (!w_accept) begin
            w_state_next = S_LEN1;
          end else if (w_cnt_big) begin
            w_state_next = S_IDLE;
          end else if (w_cnt == 16'd0) begin
            w_state_next = S_CSUM;
          end else begin
            w_state_next = S_DATA;
          end
        end
        S_DATA: w_state_next = (w_word_done && w_last_word) ? S_CSUM : S_DATA;
        S_CSUM: w_state_next = w_accept ? S_IDLE : S_CSUM;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Per-state event decode feeding the registered outputs.
  always_comb begin
    w_start     = 1'b0;
    w_len_err   = 1'b0;
    w_word_done = 1'b0;
    w_csum_ok   = 1'b0;
    w_csum_bad  = 1'b0;
    case (r_state)
      S_IDLE: w_start     = w_accept && (in_data == 8'hA5);
      S_LEN1: w_len_err   = w_accept && w_cnt_big;
      S_DATA: w_word_done = w_accept && (r_byte_idx == 2'd3);
      S_CSUM: begin
        w_csum_ok  = w_accept && (in_data == r_sum);
        w_csum_bad = w_accept && (in_data != r_sum);
      end
      default: w_start = 1'b0;
    endcase
`ifdef LOADER_TIMEOUT_EN
    w_tmo = (r_state != S_IDLE) && !w_accept && (r_tmo == TMO_LAST);
`else
    w_tmo = 1'b0;
`endif
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_ready   <= 1'b0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_hold       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cnt_lo     <= 8'd0;
      r_words_left <= 16'd0;
      r_addr       <= '0;
      r_byte_idx   <= 2'd0;
      r_asm        <= '0;
      r_sum        <= 8'd0;
    end else begin
      r_in_ready <= 1'b1;
      r_we       <= w_word_done;
      r_done     <= w_csum_ok;
      if (w_start) begin
        r_err  <= 1'b0;
        r_hold <= 1'b1;
        r_sum  <= 8'd0;
      end
      // core_hold is left high on every failure path.
      if (w_len_err || w_csum_bad || w_tmo) begin
        r_err <= 1'b1;
      end
      if (w_csum_ok) begin
        r_hold <= 1'b0;
      end
      if ((r_state == S_LEN0) && w_accept) begin
        r_cnt_lo <= in_data;
      end
      if ((r_state == S_LEN1) && w_accept) begin
        r_words_left <= w_cnt;
        r_addr       <= '0;
        r_sum        <= 8'd0;
        r_byte_idx   <= 2'd0;
      end
      if ((r_state == S_DATA) && w_accept) begin
        r_asm      <= {in_data, r_asm[DWIDTH-9:8]};
        r_sum      <= r_sum + in_data;
        r_byte_idx <= r_byte_idx + 2'd1;
      end
      // Write registers are loaded only here, so they hold between writes.
      if (w_word_done) begin
        r_waddr      <= r_addr;
        r_wdata      <= {in_data, r_asm};
        r_words_left <= r_words_left - 16'd1;
        // No increment after the last word: a full-capacity load never wraps.
        if (!w_last_word) begin
          r_addr <= r_addr + {{(AWIDTH-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign imem_we    = r_we;
  assign imem_waddr = r_waddr;
  assign imem_wdata = r_wdata;
  assign core_hold  = r_hold;
  assign load_done  = r_done;
  assign load_err   = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: reset checks, a table of fixed frames,
// hand-written multi-cycle sequences and random frames compared against a
// frame-level reference model.
module tb_imem_loader;

  localparam int AW  = 10;
  localparam int CAP = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          load_done;
  logic          load_err;

  imem_loader #(.DWIDTH(32), .AWIDTH(AW), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .core_hold(core_hold), .load_done(load_done),
    .load_err(load_err)
  );

  typedef struct {int cyc; logic [7:0] b;} acc_t;
  typedef struct {int cyc; int addr; logic [31:0] data;} wr_t;
  typedef struct {
    int n; logic [127:0] b; int nwr; int a0; logic [31:0] d0;
    int a1; logic [31:0] d1; int ndone; logic err; logic hold;
  } vec_t;

  int     cyc = 0;
  acc_t   acc_q[$];
  wr_t    wr_q[$];
  wr_t    exp_wr[$];
  int     done_q[$];
  int     exp_done[$];
  int     total = 0;
  int     bad = 0;
  logic   m_err = 1'b0;
  logic   m_hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe accepted bytes, writes and done pulses mid-cycle.
  always @(negedge clk) begin
    if (in_valid && in_ready) acc_q.push_back('{cyc, in_data});
    if (imem_we) wr_q.push_back('{cyc, int'(imem_waddr), imem_wdata});
    if (load_done) done_q.push_back(cyc);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic send_gap(input logic [7:0] b);
    if ($urandom_range(0, 3) == 0) idle(1);
    send(b);
  endtask

  task automatic clear_q();
    acc_q.delete(); wr_q.delete(); done_q.delete();
    exp_wr.delete(); exp_done.delete();
  endtask

  // Frame-level model over the list of accepted bytes.
  task automatic run_model();
    int i, n, cnt;
    logic [7:0] s;
    logic [31:0] w;
    i = 0;
    n = acc_q.size();
    while (i < n) begin
      if (acc_q[i].b != 8'hA5) begin i++; continue; end
      m_err = 1'b0; m_hold = 1'b1;
      if (i + 2 >= n) break;
      cnt = int'(acc_q[i+1].b) + 256 * int'(acc_q[i+2].b);
      i += 3;
      if (cnt > CAP) begin m_err = 1'b1; continue; end
      if (i + 4 * cnt >= n) break;
      s = 8'd0;
      for (int k = 0; k < cnt; k++) begin
        w = {acc_q[i+4*k+3].b, acc_q[i+4*k+2].b, acc_q[i+4*k+1].b, acc_q[i+4*k].b};
        s = s + w[7:0] + w[15:8] + w[23:16] + w[31:24];
        exp_wr.push_back('{acc_q[i+4*k+3].cyc + 1, k, w});
      end
      if (acc_q[i+4*cnt].b == s) begin
        m_hold = 1'b0;
        exp_done.push_back(acc_q[i+4*cnt].cyc + 1);
      end else begin
        m_err = 1'b1;
      end
      i += 4 * cnt + 1;
    end
  endtask

  task automatic check_model(input string nm);
    int nw, nd;
    run_model();
    chk({nm, " model nwr"}, wr_q.size(), exp_wr.size());
    nw = (wr_q.size() < exp_wr.size()) ? wr_q.size() : exp_wr.size();
    for (int k = 0; k < nw; k++) begin
      chk($sformatf("%s wr%0d cyc", nm, k), wr_q[k].cyc, exp_wr[k].cyc);
      chk($sformatf("%s wr%0d addr", nm, k), wr_q[k].addr, exp_wr[k].addr);
      chk($sformatf("%s wr%0d data", nm, k), wr_q[k].data, exp_wr[k].data);
    end
    chk({nm, " model ndone"}, done_q.size(), exp_done.size());
    nd = (done_q.size() < exp_done.size()) ? done_q.size() : exp_done.size();
    for (int k = 0; k < nd; k++) chk($sformatf("%s done%0d cyc", nm, k), done_q[k], exp_done[k]);
    chk({nm, " model err"}, load_err, m_err);
    chk({nm, " model hold"}, core_hold, m_hold);
    clear_q();
  endtask

  function automatic vec_t mk(int n, logic [127:0] b, int nwr, int a0, logic [31:0] d0,
                              int a1, logic [31:0] d1, int ndone, logic err, logic hold);
    vec_t v;
    v.n = n; v.b = b; v.nwr = nwr; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.ndone = ndone; v.err = err; v.hold = hold;
    return v;
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec[6];
    int cnt, nidle, ng;
    logic [7:0] s, b;

    // Bytes are right-aligned: the first byte of the frame is the leftmost.
    vec[0] = mk(12, {8'hA5,8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'hB7,8'h02,8'h01,8'h00,8'hCD},
                2, 0, 32'h00000013, 1, 32'h000102B7, 1, 1'b0, 1'b0);
    vec[1] = mk(12, {8'hA5,8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'hB7,8'h02,8'h01,8'h00,8'hCC},
                2, 0, 32'h00000013, 1, 32'h000102B7, 0, 1'b1, 1'b1);
    vec[2] = vec[0];
    vec[3] = mk(3, {8'hA5,8'h01,8'h04}, 0, 0, 32'h0, 0, 32'h0, 0, 1'b1, 1'b1);
    vec[4] = mk(7, {8'h00,8'hFF,8'h5A,8'hA5,8'h00,8'h00,8'h00}, 0, 0, 32'h0, 0, 32'h0, 1, 1'b0, 1'b0);
    vec[5] = mk(8, {8'hA5,8'h01,8'h00,8'hA5,8'hA5,8'hA5,8'hA5,8'h94},
                1, 0, 32'hA5A5A5A5, 0, 32'h0, 1, 1'b0, 1'b0);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", in_ready, 1'b0);
    chk("rst imem_we", imem_we, 1'b0);
    chk("rst waddr", imem_waddr, 0);
    chk("rst wdata", imem_wdata, 0);
    chk("rst hold", core_hold, 1'b0);
    chk("rst done", load_done, 1'b0);
    chk("rst err", load_err, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post-rst in_ready", in_ready, 1'b1);
    chk("post-rst hold", core_hold, 1'b0);
    clear_q();

    // Fixed frames.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vec[v].n; i++) send(vec[v].b[8*(vec[v].n-1-i) +: 8]);
      idle(3);
      chk($sformatf("v%0d nwr", v), wr_q.size(), vec[v].nwr);
      if (vec[v].nwr > 0 && wr_q.size() > 0) begin
        chk($sformatf("v%0d a0", v), wr_q[0].addr, vec[v].a0);
        chk($sformatf("v%0d d0", v), wr_q[0].data, vec[v].d0);
      end
      if (vec[v].nwr > 1 && wr_q.size() > 1) begin
        chk($sformatf("v%0d a1", v), wr_q[1].addr, vec[v].a1);
        chk($sformatf("v%0d d1", v), wr_q[1].data, vec[v].d1);
      end
      chk($sformatf("v%0d ndone", v), done_q.size(), vec[v].ndone);
      chk($sformatf("v%0d err", v), load_err, vec[v].err);
      chk($sformatf("v%0d hold", v), core_hold, vec[v].hold);
      check_model($sformatf("v%0d", v));
    end

    // Reset in the middle of a 2-word frame, after 6 data bytes.
    send(8'hA5); send(8'h02);
    @(negedge clk);
    chk("mid hold after A5", core_hold, 1'b1);
    send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    @(posedge clk); #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid rst in_ready", in_ready, 1'b0);
    chk("mid rst we", imem_we, 1'b0);
    chk("mid rst waddr", imem_waddr, 0);
    chk("mid rst wdata", imem_wdata, 0);
    chk("mid rst hold", core_hold, 1'b0);
    chk("mid rst err", load_err, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(3);
    chk("mid rst nwr", wr_q.size(), 1);
    if (wr_q.size() > 0) chk("mid rst w0 data", wr_q[0].data, 32'h44332211);
    m_err = 1'b0; m_hold = 1'b0;
    clear_q();
    for (int i = 0; i < vec[0].n; i++) send(vec[0].b[8*(vec[0].n-1-i) +: 8]);
    idle(3);
    check_model("after mid rst");

`ifdef LOADER_TIMEOUT_EN
    // Stall after 3 data bytes: the error must land exactly 100 idle cycles later.
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03);
    @(posedge clk); #2;
    in_valid = 1'b0;
    nidle = 0;
    while (nidle < 300) begin
      @(negedge clk);
      if (load_err) break;
      nidle++;
    end
    chk("timeout idle cycles", nidle, 100);
    chk("timeout err", load_err, 1'b1);
    chk("timeout hold", core_hold, 1'b1);
    m_err = 1'b1; m_hold = 1'b1;
    idle(2);
    clear_q();
`endif

    // Full-capacity frame.
    send(8'hA5); send(8'h00); send(8'h04);
    s = 8'd0;
    for (int k = 0; k < 4 * CAP; k++) begin
      b = 8'($urandom);
      s = s + b;
      send(b);
    end
    send(s);
    idle(3);
    chk("max nwr", wr_q.size(), CAP);
    if (wr_q.size() > 0) chk("max last addr", wr_q[wr_q.size()-1].addr, CAP - 1);
    chk("max ndone", done_q.size(), 1);
    check_model("max");

    // Random frames with garbage, gaps, bad checksums and oversize counts.
    for (int f = 0; f < 25; f++) begin
      ng = $urandom_range(0, 3);
      repeat (ng) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        send_gap(b);
      end
      send_gap(8'hA5);
      if ($urandom_range(0, 7) == 0) cnt = $urandom_range(CAP + 1, CAP + 200);
      else cnt = $urandom_range(0, 6);
      send_gap(cnt[7:0]);
      send_gap(cnt[15:8]);
      if (cnt <= CAP) begin
        s = 8'd0;
        for (int k = 0; k < 4 * cnt; k++) begin
          b = 8'($urandom);
          s = s + b;
          send_gap(b);
        end
        if ($urandom_range(0, 3) == 0) s = s + 8'd1;
        send_gap(s);
      end
      idle(3);
      check_model($sformatf("rnd%0d", f));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
